// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan path: active-low segment codes,
// the all-off bus value and the scan FSM state type.
package ssd_pkg;

    localparam logic [7:0] SSD_OFF = 8'hFF;

    // Segment order {a,b,c,d,e,f,g}; 0 lights the segment.
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } ssd_state_e;

endpackage

// File: rtl/ssd_scan_ctrl_hex7seg.sv
// Combinational hex nibble + decimal point to active-low cathode byte
// {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}.
module hex7seg
    import ssd_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       dp_i,
    output logic [7:0] cath_o
);

    logic [6:0] seg;

    always_comb begin
        seg = SEG_8;
        case (nib_i)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_8;
        endcase
        cath_o = {seg, ~dp_i};
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan scheduler with per-slot blanking
// and frame-boundary req/ack shadow update. Leading-zero blanking: SSD_LZ_SUPPRESS_EN.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 65536,
    parameter int BLANK_CYC  = 1024
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic [31:0] digits_i,
    input  logic [7:0]  dp_i,
    input  logic [7:0]  digit_en_i,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic        frame_done,
    output logic [7:0]  An,
    output logic [7:0]  Cath
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    ssd_state_e       state_q, state_d;
    logic [31:0]      sh_dig_q, sh_dig_d;
    logic [7:0]       sh_dp_q, sh_dp_d;
    logic [7:0]       sh_en_q, sh_en_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       cath_q, cath_d;
    logic             slot_end, frame_wrap, latch;
    logic [7:0]       sup_mask;
    logic [3:0]       cur_nib;
    logic             cur_dp;
    logic [7:0]       seg_cath;
    logic             lit;

    always_comb begin
        slot_end    = (slot_cnt_q == SLOT_LAST);
        frame_wrap  = slot_end && (digit_idx_q == DIGIT_LAST);
        latch       = frame_wrap && upd_req;
        slot_cnt_d  = slot_end ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (slot_end) begin
            digit_idx_d = (digit_idx_q == DIGIT_LAST) ? 3'd0 : digit_idx_q + 3'd1;
        end
        state_d = state_q;
        case (state_q)
            BLANK:   if (slot_cnt_q == BLANK_LAST) state_d = DRIVE;
            DRIVE:   if (slot_end) state_d = BLANK;
            default: state_d = BLANK;
        endcase
        sh_dig_d = latch ? digits_i   : sh_dig_q;
        sh_dp_d  = latch ? dp_i       : sh_dp_q;
        sh_en_d  = latch ? digit_en_i : sh_en_q;
    end

`ifdef SSD_LZ_SUPPRESS_EN
    logic [7:0] sh_sup_q, sh_sup_d;
    logic       seen;

    // Scan from the top digit down; everything above the first nonzero enabled digit is dark.
    always_comb begin
        sh_sup_d = sh_sup_q;
        seen     = 1'b0;
        if (latch) begin
            for (int i = 7; i >= 0; i--) begin
                seen = seen | ((i < NUM_DIGITS) && digit_en_i[i] && (digits_i[4*i +: 4] != 4'h0));
                sh_sup_d[i] = ~seen;
            end
            sh_sup_d[0] = 1'b0;
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) sh_sup_q <= '0;
        else       sh_sup_q <= sh_sup_d;
    end

    assign sup_mask = sh_sup_d;
`else
    assign sup_mask = '0;
`endif

    // Outputs are built from next-cycle values so the registered An/Cath line up with slot_cnt_q.
    assign cur_nib = sh_dig_d[{digit_idx_d, 2'b00} +: 4];
    assign cur_dp  = sh_dp_d[digit_idx_d];

    hex7seg u_hex7seg (
        .nib_i  (cur_nib),
        .dp_i   (cur_dp),
        .cath_o (seg_cath)
    );

    always_comb begin
        lit    = (state_d == DRIVE) && sh_en_d[digit_idx_d] && !sup_mask[digit_idx_d];
        an_d   = lit ? ~(8'd1 << digit_idx_d) : SSD_OFF;
        cath_d = lit ? seg_cath : SSD_OFF;
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= 3'd0;
            state_q     <= BLANK;
            sh_dig_q    <= '0;
            sh_dp_q     <= '0;
            sh_en_q     <= '0;
            an_q        <= SSD_OFF;
            cath_q      <= SSD_OFF;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
            state_q     <= state_d;
            sh_dig_q    <= sh_dig_d;
            sh_dp_q     <= sh_dp_d;
            sh_en_q     <= sh_en_d;
            an_q        <= an_d;
            cath_q      <= cath_d;
        end
    end

    assign An         = an_q;
    assign Cath       = cath_q;
    assign upd_ack    = latch;
    assign frame_done = frame_wrap;

endmodule
